// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle MIPS-subset core with one unified req/ready memory port
module cpu_multicycle #(
   parameter logic [31:0] RESET_PC        = 32'h0,
   parameter int          ADDR_W          = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic              halted,
   output logic [1:0]        trap_cause,
   output logic [31:0]       pc_o
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} cpuState;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A;

   cpuState     state, nextState;
   logic [31:0] pc, pcNext, ir, regA, regB, tgt, aluOut, mdr, aluResult;
   logic [31:0] regs [32];
   logic [1:0]  trapNext;
   logic        regWe;
   logic [4:0]  regWaddr;
   logic [31:0] regWdata;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] sextImm, zextImm, jumpTarget;
   logic        memDone, isLw, isSw, isRAlu, isJr;

   assign opcode     = ir[31:26];
   assign rs         = ir[25:21];
   assign rt         = ir[20:16];
   assign rd         = ir[15:11];
   assign funct      = ir[5:0];
   assign sextImm    = {{16{ir[15]}}, ir[15:0]};
   assign zextImm    = {16'h0, ir[15:0]};
   assign jumpTarget = {pc[31:28], ir[25:0], 2'b00};
   assign memDone    = mem_req & mem_ready;
   assign isLw       = (opcode == OP_LW);
   assign isSw       = (opcode == OP_SW);
   assign isRAlu     = (opcode == OP_RTYPE) &&
                       (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT);
   assign isJr       = (opcode == OP_RTYPE) && (funct == FN_JR);

   assign halted = (state == HALT);
   assign pc_o   = pc;

   // Default path doubles as the LW/SW effective address and ADDI sum.
   always_comb begin
      aluResult = regA + sextImm;
      if (opcode == OP_XORI) begin
         aluResult = regA ^ zextImm;
      end else if (opcode == OP_RTYPE) begin
         case (funct)
            FN_SUB:  aluResult = regA - regB;
            FN_SLT:  aluResult = {31'b0, ($signed(regA) < $signed(regB))};
            default: aluResult = regA + regB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      pcNext    = pc;
      trapNext  = trap_cause;
      regWe     = 1'b0;
      regWaddr  = rt;
      regWdata  = aluOut;
      case (state)
         FETCH: begin
            if (memDone) begin
               nextState = DECODE;
               pcNext    = pc + 32'd4;
            end
         end
         DECODE: nextState = EXEC;
         EXEC: begin
            nextState = FETCH;
            if (isRAlu || opcode == OP_ADDI || opcode == OP_XORI) begin
               nextState = WB;
            end else if (isLw || isSw) begin
               if (aluResult[1:0] != 2'b00) begin
                  nextState = HALT;
                  trapNext  = 2'd2;
               end else begin
                  nextState = MEM;
               end
            end else if (opcode == OP_BNE) begin
               if (regA != regB) pcNext = tgt;
            end else if (opcode == OP_J) begin
               pcNext = jumpTarget;
            end else if (opcode == OP_JAL) begin
               pcNext   = jumpTarget;
               regWe    = 1'b1;
               regWaddr = 5'd31;
               regWdata = pc;
            end else if (isJr) begin
               pcNext = regA;
            end else if (HALT_ON_ILLEGAL) begin
               nextState = HALT;
               trapNext  = 2'd1;
            end
         end
         MEM: begin
            if (memDone) nextState = isLw ? WB : FETCH;
         end
         WB: begin
            nextState = FETCH;
            regWe     = 1'b1;
            if (opcode == OP_RTYPE) regWaddr = rd;
            regWdata  = isLw ? mdr : aluOut;
         end
         HALT: nextState = HALT;
         default: nextState = HALT;
      endcase
   end

   // Bus outputs are set up one edge ahead so a zero-wait access completes in its first cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         ir         <= '0;
         regA       <= '0;
         regB       <= '0;
         tgt        <= '0;
         aluOut     <= '0;
         mdr        <= '0;
         trap_cause <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         pc         <= pcNext;
         trap_cause <= trapNext;
         if (state == FETCH && memDone) ir <= mem_rdata;
         if (state == DECODE) begin
            regA <= regs[rs];
            regB <= regs[rt];
            tgt  <= pc + (sextImm << 2);
         end
         if (state == EXEC) aluOut <= aluResult;
         if (state == MEM && memDone) mdr <= mem_rdata;
         if (regWe && regWaddr != 5'd0) regs[regWaddr] <= regWdata;
         mem_req <= (nextState == FETCH) || (nextState == MEM);
         if (nextState == FETCH) begin
            mem_addr <= {pcNext[ADDR_W-1:2], 2'b00};
            mem_we   <= 1'b0;
         end else if (nextState == MEM && state == EXEC) begin
            mem_addr  <= aluResult[ADDR_W-1:0];
            mem_we    <= isSw;
            mem_wdata <= regB;
         end
      end
   end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb/tb_cpu_multicycle.sv - scoreboard bench comparing bus traffic against an ISA-level reference model
module tb_cpu_multicycle;
   localparam logic [31:0] BASE = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n, mem_req, mem_we, halted;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
   logic [1:0]  trap_cause;
   logic [31:0] mem [0:1023];

   logic        nopRstN, nopReq, nopWe, nopHalted;
   logic [7:0]  nopAddr;
   logic [31:0] nopWdata, nopRdata, nopPc;
   logic [1:0]  nopTrap;
   logic [31:0] nopMem [0:15];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[11:2]];
   assign nopRdata  = nopMem[nopAddr[5:2]];

   cpu_multicycle #(.RESET_PC(BASE), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .halted(halted), .trap_cause(trap_cause), .pc_o(pc_o));

   cpu_multicycle #(.RESET_PC(32'h0), .ADDR_W(8), .HALT_ON_ILLEGAL(1'b0)) dutNop (
      .clk(clk), .rst_n(nopRstN), .mem_req(nopReq), .mem_we(nopWe), .mem_addr(nopAddr),
      .mem_wdata(nopWdata), .mem_ready(1'b1), .mem_rdata(nopRdata),
      .halted(nopHalted), .trap_cause(nopTrap), .pc_o(nopPc));

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        isFetch;
      int          gap;
   } txnT;

   txnT         expQ[$];
   int          passCnt = 0, totalCnt = 0;
   int          cycle = 0, lastFetch = 0;
   int          fixedWait = 5, waitCnt = 0, waitTarget = 0, stabViol = 0;
   bit          strictMode = 1'b0, inAccess = 1'b0;
   logic [31:0] holdAddr, holdWdata;
   logic        holdWe;
   string       testTag = "reset";

   logic [31:0] refMem [0:1023];
   logic [31:0] refRegs [32];
   logic [31:0] refPc, refPcOut;
   logic [1:0]  refCause;
   bit          refHalted;
   int          pAddr;

   int          nopStores = 0;
   logic [31:0] nopStAddr = 0, nopStData = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s/%s: got %h expected %h", testTag, name, act, exp);
   endtask

   function automatic logic [31:0] rT(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction
   function automatic logic [31:0] iT(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] jT(input logic [5:0] op, input logic [25:0] target);
      return {op, target};
   endfunction

   task automatic emit(input logic [31:0] w);
      mem[pAddr >> 2] = w;
      pAddr += 4;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      pAddr = BASE;
   endtask

   always @(posedge clk) cycle++;

   // Memory model and scoreboard monitor: acts on the falling edge, so a ready raised here
   // is the one the core samples at the next rising edge.
   task automatic observe();
      txnT e;
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      if (expQ.size() == 0) begin
         if (strictMode) begin
            totalCnt++;
            $display("FAIL %s/unexpectedAccess: got addr %h we %0d expected no access", testTag, mem_addr, mem_we);
         end
         return;
      end
      e = expQ.pop_front();
      check("busAddr", mem_addr, e.addr);
      check("busWe", {31'b0, mem_we}, {31'b0, e.we});
      if (e.we) check("busWdata", mem_wdata, e.wdata);
      if (e.isFetch) begin
         if (e.gap >= 0) check("cycles", 32'(cycle - lastFetch), 32'(e.gap));
         lastFetch = cycle;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && mem_req) begin
         if (!inAccess) begin
            inAccess   = 1'b1;
            holdAddr   = mem_addr;
            holdWe     = mem_we;
            holdWdata  = mem_wdata;
            waitCnt    = 0;
            waitTarget = (fixedWait < 0) ? int'($urandom_range(0, 3)) : fixedWait;
         end else if (mem_addr !== holdAddr || mem_we !== holdWe || (mem_we && mem_wdata !== holdWdata)) begin
            stabViol++;
         end
         if (waitCnt >= waitTarget) begin
            mem_ready = 1'b1;
            inAccess  = 1'b0;
            observe();
         end else begin
            mem_ready = 1'b0;
            waitCnt++;
         end
      end else begin
         inAccess  = 1'b0;
         mem_ready = (fixedWait < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   always @(negedge clk) begin
      if (nopRstN && nopReq && nopWe) begin
         nopStores++;
         nopStAddr = {24'h0, nopAddr};
         nopStData = nopWdata;
      end
   end

   task automatic refWr(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) refRegs[r] = v;
   endtask

   // Instruction-level model: predicts every bus transaction and the cycles each instruction costs.
   task automatic refRun(input int w, input int maxInstr);
      logic [31:0] ins, a, b, pcPlus, nextPc, sImm, ea;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      int          lat, gap;
      bit          isMem, illegal;
      gap = -1;
      for (int n = 0; n < maxInstr && !refHalted; n++) begin
         ins = refMem[refPc[11:2]];
         expQ.push_back(txnT'{refPc, 1'b0, 32'h0, 1'b1, gap});
         op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
         a = refRegs[rs]; b = refRegs[rt];
         sImm = {{16{ins[15]}}, ins[15:0]};
         pcPlus = refPc + 4; nextPc = pcPlus;
         lat = 4; isMem = 0; illegal = 0;
         case (op)
            6'h00: case (fn)
               6'h20: refWr(rd, a + b);
               6'h22: refWr(rd, a - b);
               6'h2A: refWr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               6'h08: begin nextPc = a; lat = 3; end
               default: illegal = 1;
            endcase
            6'h08: refWr(rt, a + sImm);
            6'h0E: refWr(rt, a ^ {16'h0, ins[15:0]});
            6'h23, 6'h2B: begin
               ea = a + sImm;
               if (ea[1:0] != 2'b00) begin
                  refHalted = 1; refCause = 2'd2; refPcOut = pcPlus;
               end else if (op == 6'h23) begin
                  expQ.push_back(txnT'{ea, 1'b0, 32'h0, 1'b0, -1});
                  refWr(rt, refMem[ea[11:2]]);
                  lat = 5; isMem = 1;
               end else begin
                  expQ.push_back(txnT'{ea, 1'b1, b, 1'b0, -1});
                  refMem[ea[11:2]] = b;
                  isMem = 1;
               end
            end
            6'h05: begin lat = 3; if (a != b) nextPc = pcPlus + (sImm << 2); end
            6'h02: begin lat = 3; nextPc = {pcPlus[31:28], ins[25:0], 2'b00}; end
            6'h03: begin lat = 3; nextPc = {pcPlus[31:28], ins[25:0], 2'b00}; refWr(5'd31, pcPlus); end
            default: illegal = 1;
         endcase
         if (illegal) begin
            refHalted = 1; refCause = 2'd1; refPcOut = pcPlus;
         end
         gap = (w < 0) ? -1 : lat + w * (isMem ? 2 : 1);
         refPc = nextPc;
      end
   endtask

   task automatic runProgram(input string tag, input int w, input int maxInstr);
      bit done;
      int diffs;
      @(posedge clk); #1;
      rst_n = 1'b0; strictMode = 1'b0;
      testTag = tag; fixedWait = w;
      expQ.delete();
      for (int i = 0; i < 1024; i++) refMem[i] = mem[i];
      for (int i = 0; i < 32; i++) refRegs[i] = 32'h0;
      refPc = BASE; refHalted = 0; refCause = 2'd0; refPcOut = 32'h0;
      refRun(w, maxInstr);
      repeat (2) @(posedge clk);
      #1;
      stabViol = 0; strictMode = 1'b1; rst_n = 1'b1;
      done = 0;
      for (int c = 0; c < 6000 && !done; c++) begin
         @(posedge clk); #1;
         if (expQ.size() == 0 && (!refHalted || halted)) done = 1;
      end
      if (!done) begin
         totalCnt++;
         $display("FAIL %s/timeout: got %0d pending transactions, halted %0d expected 0 pending", tag, expQ.size(), halted);
      end
      repeat (3) @(posedge clk);
      #1;
      if (refHalted) begin
         check("halted", {31'b0, halted}, 32'd1);
         check("trapCause", {30'b0, trap_cause}, {30'b0, refCause});
         check("pcO", pc_o, refPcOut);
      end
      check("busStable", 32'(stabViol), 32'd0);
      check("pending", 32'(expQ.size()), 32'd0);
      diffs = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== refMem[i]) diffs++;
      check("memImage", 32'(diffs), 32'd0);
   endtask

   task automatic genRandom();
      int r, k;
      logic [4:0] rs, rt, rd;
      clearMem();
      for (int i = 512; i < 576; i++) mem[i] = $urandom;
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 8);
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(1, 7));
         rd = 5'($urandom_range(0, 7));
         k  = $urandom_range(0, 63);
         case (r)
            0: emit(iT(6'h08, rs, rt, 16'($urandom)));
            1: emit(iT(6'h0E, rs, rt, 16'($urandom)));
            2: emit(rT(6'h20, rs, rt, rd));
            3: emit(rT(6'h22, rs, rt, rd));
            4: emit(rT(6'h2A, rs, rt, rd));
            5: emit(iT(6'h23, 5'd0, rt, 16'(32'h800 + 4 * k)));
            6: emit(iT(6'h2B, 5'd0, rs, 16'(32'h800 + 4 * k)));
            7: emit(iT(6'h05, rs, rt, 16'($urandom_range(1, 2))));
            default: emit(jT(($urandom_range(0, 1) != 0) ? 6'h03 : 6'h02, 26'((pAddr + 8) >> 2)));
         endcase
      end
      for (int r2 = 1; r2 < 32; r2++) emit(iT(6'h2B, 5'd0, 5'(r2), 16'(32'hC00 + 4 * r2)));
      emit(32'hFC000000);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; nopRstN = 1'b0;
      clearMem();
      repeat (2) @(posedge clk);
      #1;
      check("resetReq", {31'b0, mem_req}, 32'd0);
      check("resetWe", {31'b0, mem_we}, 32'd0);
      check("resetAddr", mem_addr, 32'h0);
      check("resetHalted", {31'b0, halted}, 32'd0);
      check("resetTrap", {30'b0, trap_cause}, 32'd0);
      check("resetPc", pc_o, BASE);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         if (mem_req) seen = 1;
      end
      check("firstReq", {31'b0, mem_req}, 32'd1);
      check("firstAddr", mem_addr, BASE);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midAccessReset", {31'b0, mem_req}, 32'd0);

      testTag = "nop";
      nopMem[0] = 32'hFC000000;
      nopMem[1] = iT(6'h08, 5'd0, 5'd1, 16'd7);
      nopMem[2] = iT(6'h2B, 5'd0, 5'd1, 16'h80);
      nopMem[3] = jT(6'h02, 26'd3);
      for (int i = 4; i < 16; i++) nopMem[i] = 32'h0;
      nopRstN = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("nopHalted", {31'b0, nopHalted}, 32'd0);
      check("nopTrap", {30'b0, nopTrap}, 32'd0);
      check("nopStores", 32'(nopStores), 32'd1);
      check("nopStAddr", nopStAddr, 32'h80);
      check("nopStData", nopStData, 32'd7);
      nopRstN = 1'b0;

      clearMem();
      emit(iT(6'h08, 5'd0, 5'd1, 16'hFFFB));
      emit(iT(6'h08, 5'd0, 5'd2, 16'd3));
      emit(rT(6'h2A, 5'd1, 5'd2, 5'd3));
      emit(rT(6'h22, 5'd2, 5'd1, 5'd4));
      emit(iT(6'h0E, 5'd2, 5'd5, 16'hFFFF));
      emit(rT(6'h20, 5'd1, 5'd2, 5'd0));
      emit(iT(6'h2B, 5'd0, 5'd3, 16'h40));
      emit(iT(6'h2B, 5'd0, 5'd4, 16'h44));
      emit(iT(6'h2B, 5'd0, 5'd5, 16'h48));
      emit(iT(6'h2B, 5'd0, 5'd0, 16'h4C));
      emit(32'hFC000000);
      runProgram("alu", 0, 100);
      check("sltVal", mem[16], 32'd1);
      check("subVal", mem[17], 32'd8);
      check("xoriVal", mem[18], 32'h0000FFFC);
      check("zeroReg", mem[19], 32'd0);

      clearMem();
      emit(iT(6'h08, 5'd0, 5'd4, 16'd8));
      emit(iT(6'h2B, 5'd0, 5'd4, 16'h40));
      emit(iT(6'h23, 5'd0, 5'd6, 16'h40));
      emit(iT(6'h2B, 5'd0, 5'd6, 16'h44));
      emit(32'hFC000000);
      runProgram("memWait2", 2, 100);
      check("lwVal", mem[17], 32'd8);

      clearMem();
      emit(iT(6'h08, 5'd0, 5'd1, 16'd1));
      emit(iT(6'h05, 5'd1, 5'd0, 16'd3));
      emit(iT(6'h08, 5'd0, 5'd2, 16'd99));
      emit(iT(6'h08, 5'd0, 5'd2, 16'd98));
      emit(iT(6'h08, 5'd0, 5'd2, 16'd97));
      emit(iT(6'h05, 5'd0, 5'd0, 16'd5));
      emit(jT(6'h03, 26'(32'h130 >> 2)));
      emit(iT(6'h2B, 5'd0, 5'd31, 16'h40));
      emit(iT(6'h2B, 5'd0, 5'd2, 16'h44));
      emit(32'hFC000000);
      pAddr = 32'h130;
      emit(rT(6'h08, 5'd31, 5'd0, 5'd0));
      runProgram("control", 0, 100);
      check("jalLink", mem[16], 32'h11C);
      check("bneSkip", mem[17], 32'd0);

      clearMem();
      emit(iT(6'h08, 5'd0, 5'd1, 16'd5));
      emit(iT(6'h23, 5'd0, 5'd1, 16'd2));
      runProgram("misalign", 1, 100);
      check("misalignCause", {30'b0, trap_cause}, 32'd2);

      clearMem();
      emit(32'hFC000000);
      runProgram("illegal", 0, 100);
      check("illegalCause", {30'b0, trap_cause}, 32'd1);

      for (int it = 0; it < 3; it++) begin
         genRandom();
         runProgram($sformatf("random%0d", it), -1, 300);
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
